// File: rtl/stack_rpn_sequencer.sv
// Reverse-Polish evaluator driving an external stack datapath. It mirrors the stack depth
// so that underflow, full, overflow and malformed expressions are caught, and it returns one result per expression.
module stack_rpn_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [1:0]       tok_type,
    input  logic [WIDTH-1:0] tok_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       res_err,
    output logic             busy,
    output logic [2:0]       stk_opcode,
    output logic [WIDTH-1:0] stk_data,
    input  logic [WIDTH-1:0] stk_output_data,
    input  logic             stk_empty,
    input  logic             stk_full,
    input  logic             stk_overflow
);
    localparam int            DW    = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] D_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] D_ONE = DW'(1);
    localparam logic [DW-1:0] D_TWO = DW'(2);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;
    localparam logic [1:0] T_OPND  = 2'b00;
    localparam logic [1:0] T_OPTR  = 2'b01;
    localparam logic [1:0] T_END   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_PUSH, S_ARITH, S_CHECK, S_POP, S_CAPTURE, S_FLUSH, S_DRAIN, S_RESULT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DW-1:0]    r_depth, w_depth_nxt;
    logic [3:0]       r_err, w_err_nxt;
    logic [WIDTH-1:0] r_res_data, w_res_data_nxt;
    logic [WIDTH-1:0] r_stk_data, w_stk_data_nxt;
    logic [2:0]       r_opcode, w_opcode_nxt;
    logic [3:0]       r_res_err;
    logic             r_tok_ready, r_res_valid, r_busy;
    logic             w_take;

    // tok_ready is only ever high in IDLE or FLUSH, so it alone qualifies acceptance
    assign w_take = r_tok_ready & tok_valid;

    always_comb begin
        w_state_nxt    = r_state;
        w_depth_nxt    = r_depth;
        w_err_nxt      = r_err;
        w_res_data_nxt = r_res_data;
        w_stk_data_nxt = r_stk_data;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    case (tok_type)
                        T_OPND: begin
                            if (r_depth == D_MAX || stk_full) begin
                                w_err_nxt   = 4'b0010;
                                w_state_nxt = S_FLUSH;
                            end else begin
                                w_stk_data_nxt = tok_data;
                                w_state_nxt    = S_PUSH;
                            end
                        end
                        T_OPTR: begin
                            if (r_depth < D_TWO) begin
                                w_err_nxt   = 4'b0001;
                                w_state_nxt = S_FLUSH;
                            end else begin
                                w_state_nxt = S_ARITH;
                            end
                        end
                        T_END: begin
                            if (r_depth == D_ONE) begin
                                w_state_nxt = S_POP;
                            end else if (r_depth == '0) begin
                                w_err_nxt      = 4'b0001;
                                w_res_data_nxt = '0;
                                w_state_nxt    = S_RESULT;
                            end else begin
                                w_err_nxt   = 4'b1000;
                                w_state_nxt = S_DRAIN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_PUSH: begin
                w_depth_nxt = r_depth + D_ONE;
                w_state_nxt = S_IDLE;
            end
            S_ARITH: begin
                w_depth_nxt = r_depth - D_ONE;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (stk_overflow) begin
                    w_err_nxt   = 4'b0100;
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_POP: begin
                w_depth_nxt = r_depth - D_ONE;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_res_data_nxt = stk_output_data;
                w_state_nxt    = S_RESULT;
            end
            S_FLUSH: begin
                if (w_take && tok_type == T_END) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // The pop for the last entry is issued in this cycle, so the stack is empty by RESULT
                if (r_depth <= D_ONE) begin
                    w_depth_nxt    = '0;
                    w_res_data_nxt = '0;
                    w_state_nxt    = S_RESULT;
                end else begin
                    w_depth_nxt = r_depth - D_ONE;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    w_err_nxt      = '0;
                    w_res_data_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Opcodes are registered from the next state, so each one lands exactly in its issue cycle
    always_comb begin
        w_opcode_nxt = OP_NOP;
        case (w_state_nxt)
            S_PUSH:  w_opcode_nxt = OP_PUSH;
            S_ARITH: w_opcode_nxt = {2'b10, tok_data[0]};
            S_POP:   w_opcode_nxt = OP_POP;
            S_DRAIN: if (w_depth_nxt != '0) w_opcode_nxt = OP_POP;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_depth     <= '0;
            r_err       <= '0;
            r_res_data  <= '0;
            r_stk_data  <= '0;
            r_opcode    <= OP_NOP;
            r_res_err   <= '0;
            r_tok_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_depth     <= w_depth_nxt;
            r_err       <= w_err_nxt;
            r_res_data  <= w_res_data_nxt;
            r_stk_data  <= w_stk_data_nxt;
            r_opcode    <= w_opcode_nxt;
            r_res_err   <= (w_state_nxt == S_RESULT) ? w_err_nxt : 4'b0000;
            r_tok_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_FLUSH);
            r_res_valid <= (w_state_nxt == S_RESULT);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign tok_ready  = r_tok_ready;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_err    = r_res_err;
    assign busy       = r_busy;
    assign stk_opcode = r_opcode;
    assign stk_data   = r_stk_data;

    a_res_empty: assert property (@(posedge clk) disable iff (!rst_n)
        r_res_valid |-> (r_depth == '0 && stk_empty));
    a_idle_depth: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == S_IDLE) |-> (stk_empty == (r_depth == '0)));

endmodule

// File: tb/tb_stack_rpn_sequencer.sv
// Bench for stack_rpn_sequencer: behavioural stack beside the DUT, directed scenarios and
// random expressions scored against a queue-based RPN evaluator.
module tb_stack_rpn_sequencer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             tok_valid = 1'b0;
    logic [1:0]       tok_type = 2'b00;
    logic [WIDTH-1:0] tok_data = '0;
    logic             res_ready = 1'b0;
    logic             tok_ready, res_valid, busy;
    logic [WIDTH-1:0] res_data, stk_data, stk_output_data;
    logic [3:0]       res_err;
    logic [2:0]       stk_opcode;
    logic             stk_empty, stk_full, stk_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_rpn_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type), .tok_data(tok_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .busy(busy), .stk_opcode(stk_opcode), .stk_data(stk_data),
        .stk_output_data(stk_output_data), .stk_empty(stk_empty), .stk_full(stk_full),
        .stk_overflow(stk_overflow)
    );

    // Stack datapath stand-in, reset by the same net as the DUT
    logic [WIDTH-1:0] smem [DEPTH];
    int               scnt = 0;
    logic [WIDTH-1:0] sout = '0;
    logic             sovf = 1'b0;
    int               misuse = 0;

    assign stk_empty       = (scnt == 0);
    assign stk_full        = (scnt == DEPTH);
    assign stk_overflow    = sovf;
    assign stk_output_data = sout;

    always @(posedge clk or negedge rst_n) begin : stk_model
        int r;
        if (!rst_n) begin
            scnt <= 0;
            sout <= '0;
            sovf <= 1'b0;
        end else begin
            sovf <= 1'b0;
            case (stk_opcode)
                3'b110: if (scnt < DEPTH) begin smem[scnt] <= stk_data; scnt <= scnt + 1; end
                        else misuse = misuse + 1;
                3'b100, 3'b101: begin
                    if (scnt >= 2) begin
                        r = stk_opcode[0] ? int'(smem[scnt-1]) * int'(smem[scnt-2])
                                          : int'(smem[scnt-1]) + int'(smem[scnt-2]);
                        smem[scnt-2] <= r[WIDTH-1:0];
                        scnt <= scnt - 1;
                        sovf <= (r > 255);
                    end else misuse = misuse + 1;
                end
                3'b111: if (scnt >= 1) begin sout <= smem[scnt-1]; scnt <= scnt - 1; end
                        else misuse = misuse + 1;
                3'b000: ;
                default: misuse = misuse + 1;
            endcase
        end
    end

    // Log of every issued opcode with the cycle it was issued in
    int cyc = 0;
    int op_q[$];
    int op_cyc_q[$];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && stk_opcode !== 3'b000) begin
            op_q.push_back(int'(stk_opcode));
            op_cyc_q.push_back(cyc);
        end
    end

    logic [9:0] tq[$];
    logic [7:0] e_data, g_data;
    logic [3:0] e_err, g_err;
    int e_hash, e_cnt, e_pops, g_hash, g_cnt, g_pops, g_base;
    bit g_to, g_stable, g_empty, g_busy, g_drop, g_idle_busy;

    function automatic logic [9:0] tk(input logic [1:0] t, input int v);
        return {t, 8'(v)};
    endfunction

    function automatic void emit(input int op);
        e_hash = e_hash * 5 + op;
        e_cnt  = e_cnt + 1;
        if (op == 7) e_pops = e_pops + 1;
    endfunction

    // Reference: evaluate the token list on a plain queue stack
    function automatic void ref_eval();
        int st[$];
        bit fl, done;
        int a, b, r, v;
        logic [1:0] t;
        fl = 0; done = 0;
        e_data = 0; e_err = 0; e_hash = 0; e_cnt = 0; e_pops = 0;
        for (int i = 0; i < tq.size() && !done; i++) begin
            t = tq[i][9:8];
            v = int'(tq[i][7:0]);
            if (fl) begin
                if (t == 2'b10) begin
                    repeat (st.size()) emit(7);
                    done = 1;
                end
            end else begin
                case (t)
                    2'b00: if (st.size() == DEPTH) begin e_err = 4'b0010; fl = 1; end
                           else begin st.push_back(v); emit(6); end
                    2'b01: begin
                        if (st.size() < 2) begin e_err = 4'b0001; fl = 1; end
                        else begin
                            a = st.pop_back();
                            b = st.pop_back();
                            r = v[0] ? a * b : a + b;
                            emit(v[0] ? 5 : 4);
                            st.push_back(r % 256);
                            if (r > 255) begin e_err = 4'b0100; fl = 1; end
                        end
                    end
                    2'b10: begin
                        if (st.size() == 1) begin e_data = 8'(st[0]); emit(7); end
                        else if (st.size() == 0) e_err = 4'b0001;
                        else begin e_err = 4'b1000; repeat (st.size()) emit(7); end
                        done = 1;
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    task automatic send_tok(input logic [1:0] t, input logic [7:0] d, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        tok_valid = 1'b1; tok_type = t; tok_data = d;
        while (tok_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL tok_accept: tok_ready low for %0d cycles, required high", n);
        end else @(posedge clk);
        #1 tok_valid = 1'b0;
    endtask

    task automatic run_expr(input int gap, input int hold);
        int n;
        g_base = op_q.size();
        foreach (tq[i]) send_tok(tq[i][9:8], tq[i][7:0], gap);
        n = 0;
        do begin @(negedge clk); n++; end while (res_valid !== 1'b1 && n < 300);
        g_to = (res_valid !== 1'b1);
        g_data = res_data; g_err = res_err; g_empty = stk_empty; g_busy = busy; g_stable = 1;
        repeat (hold) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== g_data || res_err !== g_err || tok_ready !== 1'b0)
                g_stable = 0;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        g_drop = (res_valid === 1'b0);
        g_idle_busy = busy;
        g_hash = 0; g_cnt = 0; g_pops = 0;
        for (int i = g_base; i < op_q.size(); i++) begin
            g_hash = g_hash * 5 + op_q[i];
            g_cnt++;
            if (op_q[i] == 7) g_pops++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tok_ready, res_valid, busy, res_err, stk_opcode, res_data, stk_data} !== 26'd0) begin
            errors++;
            $display("FAIL reset_values: got %h required 0", {tok_ready, res_valid, busy, res_err, stk_opcode, res_data, stk_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tok_ready !== 1'b1 || busy !== 1'b0 || stk_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: tok_ready %b busy %b, required 1 0", tok_ready, busy);
        end
    endtask

    task automatic test_add_hold();
        tq = '{tk(0, 3), tk(0, 4), tk(1, 0), tk(2, 0)};
        ref_eval();
        run_expr(0, 5);
        checks++;
        if (g_to || g_data !== 8'd7 || g_err !== 4'b0000) begin
            errors++; $display("FAIL add_result: data %0d err %b, required 7 0000", g_data, g_err);
        end
        checks++;
        if (g_hash !== e_hash || g_cnt !== 4) begin
            errors++; $display("FAIL add_opcodes: count %0d hash %0d, required 4 %0d", g_cnt, g_hash, e_hash);
        end
        checks++;
        if (!g_stable || !g_empty || !g_busy) begin
            errors++; $display("FAIL add_hold: stable %b empty %b busy %b, required 1 1 1", g_stable, g_empty, g_busy);
        end
        checks++;
        if (!g_drop || g_idle_busy !== 1'b0) begin
            errors++; $display("FAIL add_release: dropped %b busy %b, required 1 0", g_drop, g_idle_busy);
        end
    endtask

    task automatic test_mul_chain();
        tq = '{tk(0, 5), tk(0, 6), tk(1, 1), tk(0, 2), tk(1, 0), tk(2, 0)};
        ref_eval();
        run_expr(1, 0);
        checks++;
        if (g_data !== 8'd32 || g_err !== 4'b0000 || g_pops !== 1 || g_hash !== e_hash) begin
            errors++; $display("FAIL mul_chain: data %0d err %b pops %0d, required 32 0000 1", g_data, g_err, g_pops);
        end
    endtask

    task automatic test_underflow();
        tq = '{tk(0, 7), tk(1, 0), tk(2, 0)};
        ref_eval();
        run_expr(0, 2);
        checks++;
        if (g_data !== 8'd0 || g_err !== 4'b0001 || g_pops !== 1 || !g_empty || g_hash !== e_hash) begin
            errors++; $display("FAIL underflow: data %0d err %b pops %0d empty %b, required 0 0001 1 1", g_data, g_err, g_pops, g_empty);
        end
        tq = '{tk(2, 0)};
        ref_eval();
        run_expr(0, 0);
        checks++;
        if (g_data !== 8'd0 || g_err !== 4'b0001 || g_cnt !== 0) begin
            errors++; $display("FAIL empty_end: data %0d err %b ops %0d, required 0 0001 0", g_data, g_err, g_cnt);
        end
    endtask

    task automatic test_overflow();
        tq = '{tk(0, 255), tk(0, 1), tk(1, 0), tk(0, 9), tk(2, 0)};
        ref_eval();
        run_expr(0, 1);
        checks++;
        if (g_data !== 8'd0 || g_err !== 4'b0100 || g_pops !== 1 || g_cnt !== 4 || g_hash !== e_hash) begin
            errors++; $display("FAIL overflow: data %0d err %b pops %0d ops %0d, required 0 0100 1 4", g_data, g_err, g_pops, g_cnt);
        end
    endtask

    task automatic test_malformed();
        tq = '{tk(0, 1), tk(0, 2), tk(2, 0)};
        ref_eval();
        run_expr(0, 0);
        checks++;
        if (g_data !== 8'd0 || g_err !== 4'b1000 || g_pops !== 2 || !g_empty) begin
            errors++; $display("FAIL malformed: data %0d err %b pops %0d, required 0 1000 2", g_data, g_err, g_pops);
        end
        tq = '{tk(0, 4), tk(3, 9), tk(2, 0)};
        ref_eval();
        run_expr(0, 0);
        checks++;
        if (g_data !== 8'd4 || g_err !== 4'b0000 || g_pops !== 1) begin
            errors++; $display("FAIL after_malformed: data %0d err %b, required 4 0000", g_data, g_err);
        end
    endtask

    task automatic test_full();
        tq.delete();
        for (int i = 0; i <= DEPTH; i++) tq.push_back(tk(0, i + 1));
        tq.push_back(tk(2, 0));
        ref_eval();
        run_expr(0, 0);
        checks++;
        if (g_to || g_data !== 8'd0 || g_err !== 4'b0010 || g_pops !== DEPTH || g_hash !== e_hash || !g_empty) begin
            errors++; $display("FAIL full: err %b pops %0d empty %b, required 0010 %0d 1", g_err, g_pops, g_empty, DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        send_tok(2'b00, 8'd1, 0);
        send_tok(2'b00, 8'd2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tok_ready, res_valid, busy, res_err, stk_opcode, res_data, stk_data} !== 26'd0 || stk_empty !== 1'b1) begin
            errors++;
            $display("FAIL midreset_values: got %h required 0", {tok_ready, res_valid, busy, res_err, stk_opcode, res_data, stk_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tok_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_release: tok_ready %b busy %b, required 1 0", tok_ready, busy);
        end
        tq = '{tk(0, 4), tk(2, 0)};
        ref_eval();
        run_expr(0, 0);
        checks++;
        if (g_data !== 8'd4 || g_err !== 4'b0000 || g_pops !== 1) begin
            errors++; $display("FAIL midreset_next: data %0d err %b, required 4 0000", g_data, g_err);
        end
    endtask

    task automatic test_back_to_back();
        int pc[$];
        tq = '{tk(0, 1), tk(0, 2), tk(0, 3), tk(1, 1), tk(1, 0), tk(2, 0)};
        ref_eval();
        run_expr(0, 0);
        for (int i = g_base; i < op_q.size(); i++) if (op_q[i] == 6) pc.push_back(op_cyc_q[i]);
        checks++;
        if (pc.size() != 3 || pc[1] - pc[0] != 2 || pc[2] - pc[1] != 2) begin
            errors++; $display("FAIL push_rate: %0d pushes, spacing not 2 cycles", pc.size());
        end
        checks++;
        if (g_data !== 8'd7 || g_err !== 4'b0000 || g_hash !== e_hash) begin
            errors++; $display("FAIL back_to_back: data %0d err %b, required 7 0000", g_data, g_err);
        end
    endtask

    task automatic test_random();
        int n, v;
        for (int k = 0; k < 40; k++) begin
            tq.delete();
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 6);
                tq.push_back(tk(0, $urandom_range(0, 12)));
                for (int j = 1; j < n; j++) begin
                    tq.push_back(tk(0, $urandom_range(0, 12)));
                    if ($urandom_range(0, 9) == 0) tq.push_back(tk(3, $urandom));
                    tq.push_back(tk(1, $urandom));
                end
            end else begin
                n = $urandom_range(0, 10);
                for (int j = 0; j < n; j++) begin
                    v = $urandom_range(0, 19);
                    if (v < 9) tq.push_back(tk(0, $urandom));
                    else if (v < 17) tq.push_back(tk(1, $urandom));
                    else tq.push_back(tk(3, $urandom));
                end
            end
            tq.push_back(tk(2, $urandom));
            ref_eval();
            run_expr($urandom_range(0, 2), $urandom_range(0, 3));
            checks++;
            if (g_to || g_data !== e_data || g_err !== e_err || g_hash !== e_hash || g_cnt !== e_cnt
                || !g_stable || !g_empty || !g_drop) begin
                errors++;
                $display("FAIL random[%0d]: data %0d err %b ops %0d, required %0d %b %0d", k, g_data, g_err, g_cnt, e_data, e_err, e_cnt);
            end
        end
    endtask

    task automatic test_stack_contract();
        checks++;
        if (misuse !== 0) begin
            errors++; $display("FAIL stack_contract: %0d illegal stack operations, required 0", misuse);
        end
    endtask

    initial begin
        test_reset();
        test_add_hold();
        test_mul_chain();
        test_underflow();
        test_overflow();
        test_malformed();
        test_full();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_stack_contract();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
